// File: rtl/grf_writeback_pkg.sv
// grf_writeback_pkg
//   Shared MIPS definitions for the W-stage write-back decoder: opcode and
//   funct encodings, the write-back source selector and the load-type
//   selector consumed by load_ext.
package grf_writeback_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JALR = 6'b001001;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // COP0 rs field that identifies mfc0
  localparam logic [4:0] RS_MF   = 5'b00000;
  // Link register written by jal
  localparam logic [4:0] REG_RA  = 5'd31;

  // Which W-stage candidate result is written back
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM,
    SRC_EXT,
    SRC_MD,
    SRC_PC8,
    SRC_CP0
  } wb_src_e;

  // Width/sign of the value extracted from the raw memory word
  typedef enum logic [2:0] {
    LD_W,
    LD_H,
    LD_HU,
    LD_B,
    LD_BU
  } ld_type_e;

endpackage

// File: rtl/grf_writeback_if.sv
// grf_writeback_if
//   W-stage write-back bundle plus the D-stage register read ports.
//   master : pipeline side (drives instruction/results/read addresses)
//   slave  : grf_writeback (returns read data, write-back info, retired count)
interface grf_writeback_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_W;
  logic [31:0]      pc_W8;
  logic [31:0]      aluRet_W;
  logic [31:0]      RD_W;
  logic [31:0]      ext_W;
  logic [31:0]      mdOut_W;
  logic [31:0]      cp0rd_W;
  logic [4:0]       ra1;
  logic [4:0]       ra2;
  logic [31:0]      rd1;
  logic [31:0]      rd2;
  logic             wb_we;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] retired;

  modport master (
    output instr_W, pc_W8, aluRet_W, RD_W, ext_W, mdOut_W, cp0rd_W, ra1, ra2,
    input  rd1, rd2, wb_we, wb_addr, wb_data, retired
  );

  modport slave (
    input  instr_W, pc_W8, aluRet_W, RD_W, ext_W, mdOut_W, cp0rd_W, ra1, ra2,
    output rd1, rd2, wb_we, wb_addr, wb_data, retired
  );
endinterface

// File: rtl/grf_writeback_load_ext.sv
// load_ext
//   Extracts the loaded value from a raw little-endian memory word.
//   raw     : 32-bit word read from data memory
//   offset  : byte address bits [1:0] of the load
//   ld_type : word / halfword / byte, signed or unsigned
//   value   : 32-bit extended result
module load_ext
  import grf_writeback_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  ld_type_e    ld_type,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection: bytes by the full offset, halfwords by offset[1] only
  always_comb begin
    byte_lane = raw[7:0];
    case (offset)
      2'd1:    byte_lane = raw[15:8];
      2'd2:    byte_lane = raw[23:16];
      2'd3:    byte_lane = raw[31:24];
      default: byte_lane = raw[7:0];
    endcase
    half_lane = offset[1] ? raw[31:16] : raw[15:0];
  end

  // Sign or zero extension of the selected lane
  always_comb begin
    value = raw;
    case (ld_type)
      LD_B:    value = {{24{byte_lane[7]}}, byte_lane};
      LD_BU:   value = {24'd0, byte_lane};
      LD_H:    value = {{16{half_lane[15]}}, half_lane};
      LD_HU:   value = {16'd0, half_lane};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/grf_writeback.sv
// grf_writeback
//   W-stage write-back decode, 31x32 general register file with same-cycle
//   bypass on both read ports, and a retired-instruction counter.
//   clk   : single clock, rising edge
//   reset : asynchronous active-low; clears registers and counter
//   bus   : grf_writeback_if slave (W-stage inputs, read ports, wb outputs)
module grf_writeback
  import grf_writeback_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  grf_writeback_if.slave  bus
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  unused_shamt;

  wb_src_e     src;
  logic [4:0]  dst;
  ld_type_e    ld_type;
  logic [31:0] load_val;
  logic [31:0] src_data;
  logic        wb_we_int;
  logic [4:0]  wb_addr_int;
  logic [31:0] wb_data_int;

  logic [31:0]      regs [1:31];
  logic [CNT_W-1:0] retired_q;

  assign opcode       = bus.instr_W[31:26];
  assign rs           = bus.instr_W[25:21];
  assign rt           = bus.instr_W[20:16];
  assign rd           = bus.instr_W[15:11];
  assign unused_shamt = bus.instr_W[10:6];
  assign funct        = bus.instr_W[5:0];

  // Decode the W-stage instruction into a destination register and the
  // candidate result that feeds it; anything unlisted writes nothing.
  always_comb begin
    src     = SRC_NONE;
    dst     = 5'd0;
    ld_type = LD_W;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            src = SRC_ALU;
            dst = rd;
          end
          F_MFHI, F_MFLO: begin
            src = SRC_MD;
            dst = rd;
          end
          F_JALR: begin
            src = SRC_PC8;
            dst = rd;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU: begin
        src = SRC_ALU;
        dst = rt;
      end
      OP_LUI: begin
        src = SRC_EXT;
        dst = rt;
      end
      OP_JAL: begin
        src = SRC_PC8;
        dst = REG_RA;
      end
      OP_COP0: begin
        if (rs == RS_MF) begin
          src = SRC_CP0;
          dst = rt;
        end
      end
      OP_LW:  begin src = SRC_MEM; dst = rt; ld_type = LD_W;  end
      OP_LH:  begin src = SRC_MEM; dst = rt; ld_type = LD_H;  end
      OP_LHU: begin src = SRC_MEM; dst = rt; ld_type = LD_HU; end
      OP_LB:  begin src = SRC_MEM; dst = rt; ld_type = LD_B;  end
      OP_LBU: begin src = SRC_MEM; dst = rt; ld_type = LD_BU; end
      default: ;
    endcase
  end

  load_ext u_load_ext (
    .raw     (bus.RD_W),
    .offset  (bus.aluRet_W[1:0]),
    .ld_type (ld_type),
    .value   (load_val)
  );

  // Result mux; outputs are forced to zero when nothing is written so the
  // hazard unit never forwards a stale value or a $0 write.
  always_comb begin
    src_data = 32'd0;
    case (src)
      SRC_ALU: src_data = bus.aluRet_W;
      SRC_MEM: src_data = load_val;
      SRC_EXT: src_data = bus.ext_W;
      SRC_MD:  src_data = bus.mdOut_W;
      SRC_PC8: src_data = bus.pc_W8;
      SRC_CP0: src_data = bus.cp0rd_W;
      default: src_data = 32'd0;
    endcase
    wb_we_int   = (src != SRC_NONE) && (dst != 5'd0);
    wb_addr_int = wb_we_int ? dst : 5'd0;
    wb_data_int = wb_we_int ? src_data : 32'd0;
  end

  assign bus.wb_we   = wb_we_int;
  assign bus.wb_addr = wb_addr_int;
  assign bus.wb_data = wb_data_int;

  // Register array; wb_we already excludes $0, so addr is always 1..31 here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_we_int) begin
      regs[wb_addr_int] <= wb_data_int;
    end
  end

  // Read ports with same-cycle bypass of the W-stage write; $0 always reads 0
  always_comb begin
    bus.rd1 = 32'd0;
    bus.rd2 = 32'd0;
    if (bus.ra1 != 5'd0) begin
      if (wb_we_int && (bus.ra1 == wb_addr_int)) bus.rd1 = wb_data_int;
      else                                       bus.rd1 = regs[bus.ra1];
    end
    if (bus.ra2 != 5'd0) begin
      if (wb_we_int && (bus.ra2 == wb_addr_int)) bus.rd2 = wb_data_int;
      else                                       bus.rd2 = regs[bus.ra2];
    end
  end

  // Every non-bubble instruction retires, whether or not it writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (bus.instr_W != 32'd0) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_grf_writeback.sv
// tb_grf_writeback
//   Randomized and directed checks of grf_writeback against a behavioural
//   model: the instruction generator knows what each instruction should
//   write, and the model keeps an array of 32 registers plus a count.
module tb_grf_writeback;

  typedef enum int {
    K_BUBBLE, K_RALU, K_MFHI, K_MFLO, K_JALR, K_IALU, K_LUI, K_JAL,
    K_MFC0, K_LW, K_LH, K_LHU, K_LB, K_LBU, K_NOWRITE
  } kind_e;

  localparam logic [5:0] RALU_F [14] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26,
                                         6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02,
                                         6'h03, 6'h04, 6'h06, 6'h07};
  localparam logic [5:0] IALU_OP [7] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e,
                                         6'h0a, 6'h0b};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_writeback_if #(.CNT_W(32)) bus ();
  grf_writeback_if #(.CNT_W(3))  bus3 ();

  grf_writeback #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Narrow-counter copy used only to observe counter wrap-around
  grf_writeback #(.CNT_W(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  assign bus3.instr_W  = bus.instr_W;
  assign bus3.pc_W8    = 32'd0;
  assign bus3.aluRet_W = 32'd0;
  assign bus3.RD_W     = 32'd0;
  assign bus3.ext_W    = 32'd0;
  assign bus3.mdOut_W  = 32'd0;
  assign bus3.cp0rd_W  = 32'd0;
  assign bus3.ra1      = 5'd0;
  assign bus3.ra2      = 5'd0;

  logic [31:0] m_regs [32];
  int unsigned m_cnt;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [31:0] exp_rd1;
  logic [31:0] exp_rd2;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] encode(input kind_e k, input logic [4:0] dst);
    logic [31:0] r;
    logic [31:0] ins;
    r = $urandom;
    ins = 32'd0;
    case (k)
      K_RALU:  ins = {6'h00, r[25:16], dst, r[10:6], RALU_F[$urandom_range(13)]};
      K_MFHI:  ins = {6'h00, r[25:16], dst, r[10:6], 6'h10};
      K_MFLO:  ins = {6'h00, r[25:16], dst, r[10:6], 6'h12};
      K_JALR:  ins = {6'h00, r[25:16], dst, r[10:6], 6'h09};
      K_IALU:  ins = {IALU_OP[$urandom_range(6)], r[25:21], dst, r[15:0]};
      K_LUI:   ins = {6'h0f, r[25:21], dst, r[15:0]};
      K_JAL:   ins = {6'h03, r[25:0]};
      K_MFC0:  ins = {6'h10, 5'd0, dst, r[15:11], 11'd0};
      K_LW:    ins = {6'h23, r[25:21], dst, r[15:0]};
      K_LH:    ins = {6'h21, r[25:21], dst, r[15:0]};
      K_LHU:   ins = {6'h25, r[25:21], dst, r[15:0]};
      K_LB:    ins = {6'h20, r[25:21], dst, r[15:0]};
      K_LBU:   ins = {6'h24, r[25:21], dst, r[15:0]};
      K_NOWRITE: begin
        case ($urandom_range(4))
          0:       ins = {6'h2b, r[25:0]};                // sw
          1:       ins = {6'h04, r[25:0]};                // beq
          2:       ins = {6'h02, r[25:0]};                // j
          3:       ins = {6'h10, 5'b00100, r[20:0]};      // mtc0
          default: ins = {6'h00, r[25:6], 6'h08};         // jr
        endcase
      end
      default: ins = 32'd0;
    endcase
    return ins;
  endfunction

  function automatic logic [31:0] load_model(input kind_e k, input logic [31:0] word,
                                             input logic [1:0] a);
    logic [31:0] v;
    int o;
    o = int'(a);
    if (k == K_LB || k == K_LBU) begin
      v = (word >> (8 * o)) & 32'hFF;
      if (k == K_LB && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (k == K_LH || k == K_LHU) begin
      v = (word >> (16 * (o / 2))) & 32'hFFFF;
      if (k == K_LH && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Drive one W-stage instruction and compute what the model expects
  task automatic applyStimulus(input kind_e k, input logic [4:0] dst, input logic [31:0] ins,
                               input logic [31:0] alu, rdw, ext, md, cp0, pc8,
                               input logic [4:0] r1, r2);
    logic writes;
    logic [4:0] a;
    logic [31:0] v;
    bus.instr_W = ins;  bus.aluRet_W = alu; bus.RD_W = rdw; bus.ext_W = ext;
    bus.mdOut_W = md;   bus.cp0rd_W = cp0;  bus.pc_W8 = pc8;
    bus.ra1 = r1;       bus.ra2 = r2;
    writes = 1'b1;
    a = dst;
    v = 32'd0;
    case (k)
      K_RALU, K_IALU:         v = alu;
      K_MFHI, K_MFLO:         v = md;
      K_JALR:                 v = pc8;
      K_LUI:                  v = ext;
      K_JAL:                  begin v = pc8; a = 5'd31; end
      K_MFC0:                 v = cp0;
      K_LW, K_LH, K_LHU, K_LB, K_LBU: v = load_model(k, rdw, alu[1:0]);
      default:                writes = 1'b0;
    endcase
    exp_we   = writes && (a != 5'd0);
    exp_addr = exp_we ? a : 5'd0;
    exp_data = exp_we ? v : 32'd0;
    exp_rd1  = (r1 == 5'd0) ? 32'd0 : (exp_we && r1 == exp_addr) ? exp_data : m_regs[r1];
    exp_rd2  = (r2 == 5'd0) ? 32'd0 : (exp_we && r2 == exp_addr) ? exp_data : m_regs[r2];
  endtask

  task automatic bubble(input logic [4:0] r1, r2);
    applyStimulus(K_BUBBLE, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, r1, r2);
  endtask

  // Rising edge plus model update, returning at the following falling edge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (exp_we) m_regs[exp_addr] = exp_data;
      if (bus.instr_W != 32'd0) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    bubble(5'd0, 5'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.retired !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_retired: got %h expected 0", bus.retired);
    end
    // ori $8 under reset: decode outputs live, but no array write
    applyStimulus(K_IALU, 5'd8, 32'h34081234, 32'h1234, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd8) begin
      n_fail++; $display("[TB] FAIL reset_comb: got we=%b addr=%0d expected we=1 addr=8",
                         bus.wb_we, bus.wb_addr);
    end
    tick();
    bubble(5'd8, 5'd0);
    #1;
    n_checks++;
    if (bus.rd1 !== 32'd0 || bus.retired !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_nowrite: got rd1=%h retired=%0d expected 0/0",
                         bus.rd1, bus.retired);
    end
    reset = 1'b1;
  endtask

  task automatic test_ori_read();
    applyStimulus(K_IALU, 5'd8, 32'h34081234, 32'h1234, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd8 || bus.wb_data !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL ori_wb: got we=%b addr=%0d data=%h expected 1/8/00001234",
                         bus.wb_we, bus.wb_addr, bus.wb_data);
    end
    tick();
    bubble(5'd8, 5'd0);
    #1;
    n_checks++;
    if (bus.rd1 !== 32'h00001234) begin
      n_fail++; $display("[TB] FAIL ori_read: got %h expected 00001234", bus.rd1);
    end
  endtask

  task automatic test_loads();
    applyStimulus(K_LB, 5'd9, {6'h20, 5'd0, 5'd9, 16'h3}, 32'h3, 32'h80FF7F01, 0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.wb_data !== 32'hFFFFFF80) begin
      n_fail++; $display("[TB] FAIL lb_data: got %h expected FFFFFF80", bus.wb_data);
    end
    tick();
    applyStimulus(K_LBU, 5'd9, {6'h24, 5'd0, 5'd9, 16'h3}, 32'h3, 32'h80FF7F01, 0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.wb_data !== 32'h00000080) begin
      n_fail++; $display("[TB] FAIL lbu_data: got %h expected 00000080", bus.wb_data);
    end
    tick();
    applyStimulus(K_LH, 5'd9, {6'h21, 5'd0, 5'd9, 16'h2}, 32'h2, 32'h80FF7F01, 0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.wb_data !== 32'hFFFF80FF) begin
      n_fail++; $display("[TB] FAIL lh_data: got %h expected FFFF80FF", bus.wb_data);
    end
    tick();
    bubble(5'd9, 5'd0);
    #1;
    n_checks++;
    if (bus.rd1 !== 32'hFFFF80FF) begin
      n_fail++; $display("[TB] FAIL lh_read: got %h expected FFFF80FF", bus.rd1);
    end
  endtask

  task automatic test_bypass();
    applyStimulus(K_JAL, 5'd0, 32'h0C000100, 0, 0, 0, 0, 0, 32'h00003010, 5'd0, 5'd31);
    #1;
    n_checks++;
    if (bus.rd2 !== 32'h00003010 || bus.rd1 !== 32'd0) begin
      n_fail++; $display("[TB] FAIL jal_bypass: got rd2=%h rd1=%h expected 00003010/0",
                         bus.rd2, bus.rd1);
    end
    tick();
    bubble(5'd0, 5'd31);
    #1;
    n_checks++;
    if (bus.rd2 !== 32'h00003010) begin
      n_fail++; $display("[TB] FAIL jal_stored: got %h expected 00003010", bus.rd2);
    end
  endtask

  task automatic test_zero_dest();
    applyStimulus(K_RALU, 5'd0, {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21}, 32'hDEADBEEF,
                  0, 0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_checks++;
    if (bus.wb_we !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0 || bus.rd1 !== 32'd0) begin
      n_fail++; $display("[TB] FAIL zero_dest: got we=%b addr=%0d data=%h rd1=%h expected all 0",
                         bus.wb_we, bus.wb_addr, bus.wb_data, bus.rd1);
    end
    tick();
    n_checks++;
    if (bus.retired !== m_cnt) begin
      n_fail++; $display("[TB] FAIL zero_dest_retire: got %0d expected %0d", bus.retired, m_cnt);
    end
  endtask

  task automatic test_retire_and_reset();
    logic [31:0] val;
    // Clean start so the count is absolute
    reset = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) begin
        bubble(5'd0, 5'd0);
      end else begin
        kind_e k;
        logic [4:0] d;
        k = kind_e'($urandom_range(1, 13));
        d = 5'($urandom_range(1, 31));
        applyStimulus(k, d, encode(k, d), $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, 5'd0, 5'd0);
      end
      tick();
    end
    n_checks++;
    if (bus.retired !== 32'd8) begin
      n_fail++; $display("[TB] FAIL retire_count: got %0d expected 8", bus.retired);
    end
    // Reset asserted between edges takes effect without a clock
    bubble(5'd0, 5'd0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.retired !== 32'd0) begin
      n_fail++; $display("[TB] FAIL async_reset_cnt: got %0d expected 0", bus.retired);
    end
    for (int r = 1; r < 32; r++) begin
      bus.ra1 = 5'(r);
      #0.1;
      n_checks++;
      if (bus.rd1 !== 32'd0) begin
        n_fail++; $display("[TB] FAIL async_reset_reg%0d: got %h expected 0", r, bus.rd1);
      end
    end
    // First edge after release performs the normal write and count
    @(negedge clk);
    reset = 1'b1;
    val = $urandom;
    applyStimulus(K_IALU, 5'd8, 32'h35080000, val, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    tick();
    bubble(5'd8, 5'd0);
    #1;
    n_checks++;
    if (bus.retired !== 32'd1 || bus.rd1 !== val) begin
      n_fail++; $display("[TB] FAIL release_first_edge: got cnt=%0d rd1=%h expected 1/%h",
                         bus.retired, bus.rd1, val);
    end
  endtask

  task automatic test_cp0_mflo();
    applyStimulus(K_MFC0, 5'd5, {6'h10, 5'd0, 5'd5, 5'd12, 11'd0}, 0, 0, 0, 0, 32'h0000FC01, 0,
                  5'd0, 5'd0);
    tick();
    applyStimulus(K_MFLO, 5'd6, {6'h00, 10'd0, 5'd6, 5'd0, 6'h12}, 0, 0, 0, 32'd7, 0, 0,
                  5'd0, 5'd0);
    tick();
    bubble(5'd5, 5'd6);
    #1;
    n_checks++;
    if (bus.rd1 !== 32'h0000FC01 || bus.rd2 !== 32'h00000007) begin
      n_fail++; $display("[TB] FAIL cp0_mflo: got rd1=%h rd2=%h expected 0000FC01/00000007",
                         bus.rd1, bus.rd2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      kind_e k;
      logic [4:0] d, r1, r2;
      k  = kind_e'($urandom_range(0, 14));
      d  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom);
      r1 = ($urandom_range(2) == 0) ? (k == K_JAL ? 5'd31 : d) : 5'($urandom);
      r2 = ($urandom_range(2) == 0) ? d : 5'($urandom);
      applyStimulus(k, d, encode(k, d), $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, r1, r2);
      #1;
      n_checks++;
      if (bus.wb_we !== exp_we || bus.wb_addr !== exp_addr || bus.wb_data !== exp_data) begin
        n_fail++; $display("[TB] FAIL rand_wb[%0d] kind=%0d: got %b/%0d/%h expected %b/%0d/%h",
                           i, k, bus.wb_we, bus.wb_addr, bus.wb_data, exp_we, exp_addr, exp_data);
      end
      n_checks++;
      if (bus.rd1 !== exp_rd1 || bus.rd2 !== exp_rd2) begin
        n_fail++; $display("[TB] FAIL rand_read[%0d]: got %h/%h expected %h/%h",
                           i, bus.rd1, bus.rd2, exp_rd1, exp_rd2);
      end
      tick();
      n_checks++;
      if (bus.retired !== m_cnt || bus3.retired !== 3'(m_cnt % 8)) begin
        n_fail++; $display("[TB] FAIL rand_retired[%0d]: got %0d/%0d expected %0d/%0d",
                           i, bus.retired, bus3.retired, m_cnt, m_cnt % 8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ori_read();
    test_loads();
    test_bypass();
    test_zero_dest();
    test_cp0_mflo();
    test_retire_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
